// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-through cache controller.
// Holds the address geometry, field positions inside a CPU word address,
// the controller state encoding and small address-field helpers.
package cache_pkg;

    localparam int ADDR_WIDTH     = 10;
    localparam int DATA_WIDTH     = 32;
    localparam int LINE_WIDTH     = 128;
    localparam int INDEX_WIDTH    = 5;
    localparam int OFFSET_WIDTH   = 2;
    localparam int TAG_WIDTH      = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int NUM_LINES      = 1 << INDEX_WIDTH;
    localparam int WORDS_PER_LINE = 1 << OFFSET_WIDTH;

    // Field positions inside cpu_addr = {tag, index, offset}
    localparam int OFFSET_LSB = 0;
    localparam int INDEX_LSB  = OFFSET_LSB + OFFSET_WIDTH;
    localparam int TAG_LSB    = INDEX_LSB + INDEX_WIDTH;

    typedef logic [ADDR_WIDTH-1:0]   addr_t;
    typedef logic [DATA_WIDTH-1:0]   word_t;
    typedef logic [LINE_WIDTH-1:0]   line_t;
    typedef logic [TAG_WIDTH-1:0]    tag_t;
    typedef logic [INDEX_WIDTH-1:0]  index_t;
    typedef logic [OFFSET_WIDTH-1:0] offset_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FILL      = 2'd1,
        ST_REFILL    = 2'd2,
        ST_WRITE_MEM = 2'd3
    } state_t;

    function automatic tag_t addr_tag(input addr_t a);
        return a[TAG_LSB +: TAG_WIDTH];
    endfunction

    function automatic index_t addr_index(input addr_t a);
        return a[INDEX_LSB +: INDEX_WIDTH];
    endfunction

    function automatic offset_t addr_offset(input addr_t a);
        return a[OFFSET_LSB +: OFFSET_WIDTH];
    endfunction

endpackage

// File: rtl/cache_controller_if.sv
// Bus bundle of the cache controller: CPU request/stall handshake, the
// valid/ready word interface to main memory and the data-array control.
//   slave  : the controller (consumes CPU/memory inputs, drives the rest)
//   master : the environment (CPU, main memory, data array)
interface cache_controller_if;
    import cache_pkg::*;

    logic    cpu_read;
    logic    cpu_write;
    addr_t   cpu_addr;
    word_t   cpu_wdata;
    logic    stall;
    logic    mem_read;
    logic    mem_write;
    addr_t   mem_addr;
    word_t   mem_wdata;
    word_t   mem_rdata;
    logic    mem_ready;
    logic    refill;
    logic    update;
    index_t  index;
    offset_t offset;
    line_t   line_data;
    word_t   write_data;

    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        output stall, mem_read, mem_write, mem_addr, mem_wdata,
               refill, update, index, offset, line_data, write_data
    );

    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        input  stall, mem_read, mem_write, mem_addr, mem_wdata,
               refill, update, index, offset, line_data, write_data
    );

endinterface

// File: rtl/cache_tag_array.sv
// Tag store: 32 entries of {valid, tag}. Synchronous clear on rst,
// one write port (sets valid and loads the tag), combinational read.
// Ports: clk, rst, rd_index -> rd_valid/rd_tag, wr_en/wr_index/wr_tag.
module cache_tag_array
    import cache_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  index_t rd_index,
    output logic   rd_valid,
    output tag_t   rd_tag,
    input  logic   wr_en,
    input  index_t wr_index,
    input  tag_t   wr_tag
);

    logic [NUM_LINES-1:0] valid_r;
    tag_t                 tag_r [NUM_LINES];

    // Valid/tag storage: reset invalidates every line, a write installs one
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= {NUM_LINES{1'b0}};
            for (int i = 0; i < NUM_LINES; i++) begin
                tag_r[i] <= {TAG_WIDTH{1'b0}};
            end
        end else if (wr_en) begin
            valid_r[wr_index] <= 1'b1;
            tag_r[wr_index]   <= wr_tag;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign rd_valid = valid_r[rd_index];
    assign rd_tag   = tag_r[rd_index];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Owns tags/valid bits, stalls the CPU on misses and stores, fetches 4-word
// lines from main memory and drives refill/update into the data array.
// Ports: clk, rst (sync, active-high), bus (cache_controller_if.slave):
//   CPU: cpu_read/cpu_write/cpu_addr/cpu_wdata in, stall out
//   MEM: mem_read/mem_write/mem_addr/mem_wdata out, mem_rdata/mem_ready in
//   ARRAY: refill/update/index/offset/line_data/write_data out
module cache_controller
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    cache_controller_if.slave  bus
);

    state_t  state_r;
    state_t  state_nxt_s;
    offset_t beat_r;
    word_t   line_buf_r [WORDS_PER_LINE];

    tag_t    req_tag_s;
    index_t  req_index_s;
    offset_t req_offset_s;
    logic    tag_valid_s;
    tag_t    tag_stored_s;
    logic    hit_s;
    logic    beat_last_s;

    logic    stall_s;
    logic    mem_read_s;
    logic    mem_write_s;
    addr_t   mem_addr_s;
    logic    refill_s;
    logic    update_s;
    logic    tag_we_s;

    assign req_tag_s    = addr_tag(bus.cpu_addr);
    assign req_index_s  = addr_index(bus.cpu_addr);
    assign req_offset_s = addr_offset(bus.cpu_addr);

    cache_tag_array u_tag_array (
        .clk      (clk),
        .rst      (rst),
        .rd_index (req_index_s),
        .rd_valid (tag_valid_s),
        .rd_tag   (tag_stored_s),
        .wr_en    (tag_we_s),
        .wr_index (req_index_s),
        .wr_tag   (req_tag_s)
    );

    assign hit_s       = tag_valid_s && (tag_stored_s == req_tag_s);
    assign beat_last_s = (beat_r == 2'd3);

    // Next-state and control outputs; everything is forced idle while rst is high
    always_comb begin
        state_nxt_s = state_r;
        stall_s     = 1'b0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        mem_addr_s  = bus.cpu_addr;
        refill_s    = 1'b0;
        update_s    = 1'b0;
        tag_we_s    = 1'b0;
        if (rst) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // A store wins over a simultaneous load
                    if (bus.cpu_write) begin
                        stall_s     = 1'b1;
                        state_nxt_s = ST_WRITE_MEM;
                    end else if (bus.cpu_read) begin
                        if (hit_s) begin
                            stall_s = 1'b0;
                        end else begin
                            stall_s     = 1'b1;
                            state_nxt_s = ST_FILL;
                        end
                    end else begin
                        stall_s = 1'b0;
                    end
                end
                ST_FILL: begin
                    // Whole line fetched in order 0..3, independent of the CPU offset
                    stall_s    = 1'b1;
                    mem_read_s = 1'b1;
                    mem_addr_s = {req_tag_s, req_index_s, beat_r};
                    if (bus.mem_ready && beat_last_s) begin
                        state_nxt_s = ST_REFILL;
                    end else begin
                        state_nxt_s = ST_FILL;
                    end
                end
                ST_REFILL: begin
                    stall_s     = 1'b1;
                    refill_s    = 1'b1;
                    tag_we_s    = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
                ST_WRITE_MEM: begin
                    mem_write_s = 1'b1;
                    if (bus.mem_ready) begin
                        // No write allocate: the array word is touched only on a hit
                        stall_s     = 1'b0;
                        update_s    = hit_s;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        stall_s = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Beat counter and line buffer capture during a fill
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_r <= 2'd0;
            for (int i = 0; i < WORDS_PER_LINE; i++) begin
                line_buf_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    beat_r <= 2'd0;
                end
                ST_FILL: begin
                    if (bus.mem_ready) begin
                        line_buf_r[beat_r] <= bus.mem_rdata;
                        beat_r             <= beat_r + 2'd1;
                    end else begin
                        beat_r <= beat_r;
                    end
                end
                default: begin
                    beat_r <= beat_r;
                end
            endcase
        end
    end

    assign bus.stall      = stall_s;
    assign bus.mem_read   = mem_read_s;
    assign bus.mem_write  = mem_write_s;
    assign bus.mem_addr   = mem_addr_s;
    assign bus.mem_wdata  = bus.cpu_wdata;
    assign bus.refill     = refill_s;
    assign bus.update     = update_s;
    assign bus.index      = req_index_s;
    assign bus.offset     = req_offset_s;
    assign bus.line_data  = {line_buf_r[3], line_buf_r[2], line_buf_r[1], line_buf_r[0]};
    assign bus.write_data = bus.cpu_wdata;

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: stimulus pushes the expected
// memory beats, refills, updates and request completions (with latency)
// into a queue; a negedge monitor pops and compares as the DUT produces them.
module tb_cache_controller;
    import cache_pkg::*;

    localparam int K_RBEAT  = 0;
    localparam int K_WBEAT  = 1;
    localparam int K_REFILL = 2;
    localparam int K_UPDATE = 3;
    localparam int K_DONE   = 4;

    typedef struct {
        string        name;
        int           kind;
        logic [31:0]  a;
        logic [127:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic ready_en;
    int   vectors = 0;
    int   miscompares = 0;
    int   done_cnt = 0;
    int   lat = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    cache_controller_if bus();

    cache_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Main memory model: word at address a holds {A5, zeros, a}
    function automatic word_t mem_word(input addr_t a);
        return {8'hA5, 14'h0000, a};
    endfunction

    assign bus.mem_rdata = mem_word(bus.mem_addr);
    assign bus.mem_ready = ready_en;

    task automatic push(input string n, input int k, input logic [31:0] a, input logic [127:0] d);
        exp_t e;
        e.name = n; e.kind = k; e.a = a; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic chk(input int kind, input logic [31:0] a, input logic [127:0] d);
        exp_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: actual kind=%0d a=%0h d=%0h, required no event", kind, a, d);
            miscompares++;
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.a != a || e.d != d) begin
                $display("FAIL %s: actual kind=%0d a=%0h d=%0h, required kind=%0d a=%0h d=%0h",
                         e.name, kind, a, d, e.kind, e.a, e.d);
                miscompares++;
            end
        end
    endtask

    // Expected events of a read miss: 4 ordered beats, one refill, completion after 7 cycles
    task automatic exp_read_miss(input addr_t addr);
        addr_t        base;
        logic [127:0] line;
        base = addr & 10'h3FC;
        line = {mem_word(base | 10'd3), mem_word(base | 10'd2), mem_word(base | 10'd1), mem_word(base)};
        for (int k = 0; k < 4; k++) begin
            push("fill_beat", K_RBEAT, {22'd0, base | 10'(k)}, 128'd0);
        end
        push("refill_line", K_REFILL, {27'd0, addr_index(addr)}, line);
        push("miss_latency", K_DONE, 32'd7, 128'd0);
    endtask

    task automatic exp_write(input addr_t addr, input word_t wd, input logic is_hit);
        push("write_beat", K_WBEAT, {22'd0, addr}, {96'd0, wd});
        if (is_hit) begin
            push("write_update", K_UPDATE, {25'd0, addr_index(addr), addr_offset(addr)}, {96'd0, wd});
        end
        push("write_latency", K_DONE, 32'd2, 128'd0);
    endtask

    // Present one request and hold it until the monitor sees it complete
    task automatic issue(input logic rd, input logic wr, input addr_t a, input word_t wd);
        int start;
        @(posedge clk);
        #1;
        bus.cpu_read  = rd;
        bus.cpu_write = wr;
        bus.cpu_addr  = a;
        bus.cpu_wdata = wd;
        start = done_cnt;
        for (int i = 0; i < 60 && done_cnt == start; i++) begin
            @(posedge clk);
        end
        vectors++;
        if (done_cnt == start) begin
            $display("FAIL request_timeout: actual no completion, required completion for addr %0h", a);
            miscompares++;
        end
        #1;
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
    endtask

    // Monitor: compares every DUT event against the scoreboard queue
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                lat = 0;
            end else begin
                if (bus.mem_read || bus.mem_write || bus.refill || bus.update) begin
                    vectors++;
                    if ((bus.mem_read && bus.mem_write) || (bus.refill && bus.update)) begin
                        $display("FAIL exclusive_strobes: actual rd=%b wr=%b refill=%b update=%b, required pairs not both 1",
                                 bus.mem_read, bus.mem_write, bus.refill, bus.update);
                        miscompares++;
                    end
                end
                if (bus.mem_read && bus.mem_ready)
                    chk(K_RBEAT, {22'd0, bus.mem_addr}, 128'd0);
                if (bus.mem_write && bus.mem_ready)
                    chk(K_WBEAT, {22'd0, bus.mem_addr}, {96'd0, bus.mem_wdata});
                if (bus.refill)
                    chk(K_REFILL, {27'd0, bus.index}, bus.line_data);
                if (bus.update)
                    chk(K_UPDATE, {25'd0, bus.index, bus.offset}, {96'd0, bus.write_data});
                if (bus.cpu_read || bus.cpu_write) begin
                    lat++;
                    if (!bus.stall) begin
                        chk(K_DONE, lat, 128'd0);
                        lat = 0;
                        done_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        ready_en      = 1'b1;
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_addr  = 10'h000;
        bus.cpu_wdata = 32'h0000_0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({bus.stall, bus.mem_read, bus.mem_write, bus.refill, bus.update} != 5'b00000) begin
            $display("FAIL reset_outputs: actual %b, required 00000",
                     {bus.stall, bus.mem_read, bus.mem_write, bus.refill, bus.update});
            miscompares++;
        end
        @(posedge clk);
        #1 rst = 1'b0;

        exp_read_miss(10'h004);                 issue(1'b1, 1'b0, 10'h004, 32'h0);
        push("hit_latency", K_DONE, 32'd1, 128'd0); issue(1'b1, 1'b0, 10'h006, 32'h0);
        exp_read_miss(10'h084);                 issue(1'b1, 1'b0, 10'h084, 32'h0);
        exp_read_miss(10'h004);                 issue(1'b1, 1'b0, 10'h004, 32'h0);
        exp_write(10'h005, 32'hDEAD_BEEF, 1'b1); issue(1'b0, 1'b1, 10'h005, 32'hDEAD_BEEF);
        push("hit_latency", K_DONE, 32'd1, 128'd0); issue(1'b1, 1'b0, 10'h005, 32'h0);
        exp_write(10'h3FC, 32'h1234_5678, 1'b0); issue(1'b0, 1'b1, 10'h3FC, 32'h1234_5678);
        exp_read_miss(10'h3FC);                 issue(1'b1, 1'b0, 10'h3FC, 32'h0);

        // Fill of 0x104 stalls after two beats, then reset aborts it
        push("fill_beat", K_RBEAT, 32'h104, 128'd0);
        push("fill_beat", K_RBEAT, 32'h105, 128'd0);
        @(posedge clk);
        #1;
        bus.cpu_read = 1'b1;
        bus.cpu_addr = 10'h104;
        repeat (3) @(posedge clk);
        #1 ready_en = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (!(bus.stall && bus.mem_read && bus.mem_addr == 10'h106)) begin
            $display("FAIL fill_wait: actual stall=%b rd=%b addr=%0h, required 1 1 106",
                     bus.stall, bus.mem_read, bus.mem_addr);
            miscompares++;
        end
        @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.cpu_read = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.stall, bus.mem_read, bus.mem_write, bus.refill, bus.update} != 5'b00000) begin
            $display("FAIL abort_outputs: actual %b, required 00000",
                     {bus.stall, bus.mem_read, bus.mem_write, bus.refill, bus.update});
            miscompares++;
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        ready_en = 1'b1;
        vectors++;
        if (exp_q.size() != 0) begin
            $display("FAIL abort_pending: actual %0d events outstanding, required 0", exp_q.size());
            miscompares++;
        end

        exp_read_miss(10'h004);                 issue(1'b1, 1'b0, 10'h004, 32'h0);
        push("hit_latency", K_DONE, 32'd1, 128'd0); issue(1'b1, 1'b0, 10'h006, 32'h0);

        repeat (3) @(posedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            $display("FAIL leftover_events: actual %0d outstanding, required 0", exp_q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
